// File: rtl/task_4_output.sv
// task_4_output: 9-bit packet FIFO feeding a store-and-forward stream output.
// A packet is only released once its last byte has been written.
module task_4_output #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_enb,
    input  logic       i_last,
    input  logic       i_tready,
    output logic [7:0] o_tdata,
    output logic       o_tvalid,
    output logic       o_tdata_last,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_busy,
    output logic       o_overflow
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
    state_t      r_state;
    logic [8:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr, r_rptr, r_pkt_cnt;
    logic [7:0]  r_tdata;
    logic        r_tlast, r_tvalid, r_busy, r_ovf;
    logic        w_wr, w_hs, w_pop;
    logic [8:0]  w_head;
    assign o_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty      = r_wptr == r_rptr;
    assign w_wr         = i_enb && !o_full;
    assign w_hs         = r_tvalid && i_tready;
    assign w_pop        = (r_state == LOAD) || (w_hs && !r_tlast);
    assign w_head       = r_mem[r_rptr[AW-1:0]];
    assign o_tdata      = r_tdata;
    assign o_tdata_last = r_tlast;
    assign o_tvalid     = r_tvalid;
    assign o_busy       = r_busy;
    assign o_overflow   = r_ovf;
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= {i_last, i_data};
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_pkt_cnt <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (i_enb && o_full) r_ovf <= 1'b1;
            r_pkt_cnt <= r_pkt_cnt + (AW+1)'(w_wr && i_last) - (AW+1)'(w_hs && r_tlast);
        end
    end
    // Output register is loaded in LOAD and refilled on every non-last handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (r_pkt_cnt != '0) begin
                    r_state <= LOAD;
                    r_busy  <= 1'b1;
                end
                LOAD: begin
                    r_tdata  <= w_head[7:0];
                    r_tlast  <= w_head[8];
                    r_tvalid <= 1'b1;
                    r_state  <= SEND;
                end
                SEND: if (w_hs) begin
                    if (r_tlast) begin
                        r_tvalid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_tdata <= w_head[7:0];
                        r_tlast <= w_head[8];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/task_4_output.md
TASK_4_OUTPUT -- requirements
Module: task_4_output

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entry count (power of two, >= 4).
REQ-002 SHALL have parameter AW, default log2(DEPTH), meaning FIFO address width.
REQ-003 SHALL have port i_clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_data  input  8  processed byte from the upstream task core.
REQ-006 SHALL have port i_enb  input  1  write strobe; i_data/i_last sampled when high.
REQ-007 SHALL have port i_last  input  1  marks the final byte of a packet.
REQ-008 SHALL have port i_tready  input  1  stream sink ready.
REQ-009 SHALL have port o_tdata  output  8  stream data.
REQ-010 SHALL have port o_tvalid  output  1  stream valid.
REQ-011 SHALL have port o_tdata_last  output  1  stream last; valid only with o_tvalid.
REQ-012 SHALL have port o_full, o_empty  output  1 each  FIFO status.
REQ-013 SHALL have port o_busy  output  1  high while a packet is being transmitted.
REQ-014 SHALL have port o_overflow  output  1  sticky flag: a write was dropped.

Function
REQ-015 SHALL store each accepted byte with its last bit (9-bit entry) in a DEPTH-entry circular FIFO; pointers wrap DEPTH-1 -> 0.
REQ-016 SHALL accept a write when i_enb=1 and o_full=0; i_enb=1 while o_full=1 SHALL drop the byte and set o_overflow, even if a pop occurs in the same cycle.
REQ-017 SHALL keep an (AW+1)-bit packet counter: +1 on accepted write with i_last=1, -1 on handshake (o_tvalid & i_tready) with o_tdata_last=1; both in one cycle SHALL leave it unchanged.
REQ-018 SHALL be store-and-forward: transmission of a packet SHALL start only when packet counter > 0.
REQ-019 SHALL implement FSM IDLE, LOAD, SEND; IDLE -> LOAD when packet counter > 0; LOAD -> SEND unconditionally; SEND -> IDLE on handshake with o_tdata_last=1; otherwise hold.
REQ-020 SHALL, in LOAD, pop the FIFO head into registered o_tdata/o_tdata_last.
REQ-021 SHALL drive o_tvalid=1 exactly in SEND; o_tdata/o_tdata_last SHALL stay stable while o_tvalid=1 and i_tready=0.
REQ-022 SHALL, on handshake of a non-last beat in SEND, pop the next entry into the output register in the same edge, giving one beat per cycle with i_tready held high.
REQ-023 SHALL give latency: last byte written at edge k (IDLE, counter 0) -> o_tvalid=1 after edge k+2; two idle cycles (IDLE, LOAD) between back-to-back packets.
REQ-024 SHALL drive o_busy=1 in LOAD and SEND, 0 in IDLE.
REQ-025 SHALL derive o_full/o_empty combinationally from pointers (one extra wrap bit); o_empty reflects entries not yet popped into the output register.
REQ-026 SHALL NOT force transmission when full with packet counter 0 (packet > DEPTH); block stays IDLE, further writes drop and set o_overflow.
REQ-027 SHALL allow writes in any state, including the cycle of a pop.

Reset
REQ-028 SHALL, on i_rst_n=0, immediately clear pointers, packet counter, FSM (IDLE), o_tvalid, o_tdata, o_tdata_last, o_busy, o_overflow to 0, o_full=0, o_empty=1.
REQ-029 SHALL discard a packet in progress on reset; o_tvalid SHALL fall asynchronously; operation resumes on first edge after i_rst_n=1.
REQ-030 SHALL clear o_overflow only by reset.

Verification
REQ-031 SHALL cover: write 0x11,0x22,0x33(last) with i_tready=1 -> o_tvalid high 2 cycles after last write, beats 0x11,0x22,0x33 on consecutive cycles, o_tdata_last only on 0x33, o_busy falls after.
REQ-032 SHALL cover: same packet, i_tready toggled 1,0,0,1 -> data/last held stable during stall, no beat lost or repeated.
REQ-033 SHALL cover: two 4-byte packets back-to-back -> 2 idle cycles between packets, packet counter 2->1->0.
REQ-034 SHALL cover: DEPTH+1 bytes, no last -> o_full=1 after 16 writes, 17th dropped, o_overflow=1, o_tvalid stays 0.
REQ-035 SHALL cover: i_rst_n pulsed low mid-SEND of an 8-byte packet -> o_tvalid=0 immediately, o_empty=1, next packet transmits correctly.
REQ-036 SHALL cover: write with i_last coincident with last-beat handshake of previous packet -> counter unchanged, new packet starts via IDLE->LOAD->SEND.
